mmio_timer: RTL and testbench
=============================

# mmio_timer

Memory-mapped timer peripheral that responds on the processor data bus alongside `mem`. It decodes a 32-byte window and implements a prescaled 32-bit up-counter with compare match, auto-reload and an interrupt line. Writes use the same timing as `mem`: write-enable qualified, synchronous on the clock edge. Reads use the same timing as `mem`: combinational from address. The top level routes `ReadData` from this block when `hit` is high.

## Interface
- `BASE_ADR`, 32'h0000_1000: byte base of the window; must be 32-byte aligned.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `Adress`  in  32: byte address from the processor.
- `write_enable`  in  1: write strobe; full-word writes only.
- `WriteData`  in  32: write data.
- `ReadData`  out  32: combinational read data for the addressed register.
- `hit`  out  1: combinational; high when `Adress[31:5] == BASE_ADR[31:5]`.
- `irq`  out  1: interrupt; equals `STATUS.match & CTRL.irq_en`.

## Operation
- Register map (word offset is `Adress[4:2]`; `Adress[1:0]` is ignored):
  - 0 CTRL[2:0]: bit 0 `en`, bit 1 `auto_reload`, bit 2 `irq_en`. Reads return zero-extended.
  - 1 PRESCALE[15:0]: reads return zero-extended.
  - 2 COUNT[31:0]
  - 3 COMPARE[31:0]
  - 4 STATUS[0] `match`: write-1-to-clear; writing 0 has no effect.
  - 5–7: reserved. Reads return 0; writes are ignored; `hit` is still high.
- A register is written only when `write_enable & hit`. Writes with `hit` low change no state.
- `ReadData` is 0 when `hit` is low.
- Internal prescale counter `pre[15:0]`:
  - While `en` is high: if `pre == PRESCALE`, then `pre <= 0` and the cycle is a tick; otherwise `pre <= pre + 1`.
  - While `en` is low: `pre` holds and no ticks occur.
  - PRESCALE = 0 gives a tick every enabled cycle.
- On a tick:
  - If `COUNT == COMPARE`: `match <= 1`. Then `COUNT <= 0` if `auto_reload` is set, else `COUNT <= COUNT + 1`.
  - Otherwise `COUNT <= COUNT + 1`.
  - Increment is modulo 2^32: 32'hFFFF_FFFF wraps to 0 with no flag.
- Writes to PRESCALE or CTRL also reset `pre` to 0, so a new rate starts cleanly.
- Simultaneous events:
  - Software write to COUNT in a tick cycle: the written value wins; the increment is lost. The match compare uses the pre-write COUNT.
  - STATUS W1C in the same cycle as a match set: set wins and `match` stays 1.
  - CTRL write clearing `en` in a tick cycle: that tick still completes, because the decision uses the pre-write `en`.

## Timing
- Reset: CTRL, PRESCALE, COUNT, COMPARE, `match` and `pre` all become 0. After reset `irq` = 0. `ReadData` and `hit` follow `Adress` combinationally; reading any register returns 0.
- Read latency is 0 cycles: `ReadData` is valid in the same cycle as `Adress`. The multicycle processor samples it at its next edge.
- Write latency: the value is visible to reads in the cycle after the write edge.
- First tick after setting `en` (with `pre` = 0) occurs at the edge ending the (PRESCALE+1)-th enabled cycle. COUNT then shows the incremented value on the following cycle.
- `match` and `irq` rise in the cycle after the tick edge on which COUNT == COMPARE.
- `reset` asserted mid-count clears everything at that edge regardless of `write_enable`.

## Test plan
- Reset and decode:
  - Assert `reset` for 2 cycles with `Adress` = 32'h1008 → `ReadData` = 0, `hit` = 1, `irq` = 0.
  - `Adress` = 32'h1020 → `hit` = 0, `ReadData` = 0.
  - A write with `WriteData` = 32'hDEAD to 32'h1020 → COUNT, COMPARE, PRESCALE and CTRL are unchanged.
- Prescale and count:
  - Set PRESCALE = 3 and CTRL = 1 → COUNT reads 1 after 4 enabled cycles and 5 after 20.
  - Clear `en` → COUNT holds at 5 for 10 cycles.
- One-shot match:
  - Set PRESCALE = 0, COMPARE = 4, CTRL = 5 (`en` + `irq_en`) → `irq` rises on the cycle after the tick at COUNT = 4, and COUNT then continues to 5.
  - Write STATUS = 1 → `irq` falls on the next cycle.
- Auto-reload:
  - Set PRESCALE = 0, COMPARE = 2, CTRL = 7 → COUNT cycles 0, 1, 2, 0, 1, 2.
  - A STATUS W1C issued on a tick with COUNT = 2 → `match` stays 1.
- Wrap and write priority:
  - Write COUNT = 32'hFFFF_FFFF with PRESCALE = 0, `en` = 1, COMPARE = 5 → the next read is 0 and `match` stays 0.
  - Write COUNT = 32'h100 on a tick cycle → the next read is 32'h100, not 32'h101.
- Reset mid-operation:
  - With COUNT = 7 and `match` = 1, assert `reset` for one cycle with `write_enable` = 1 → all registers read 0 and `irq` = 0.

Source files
------------

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped prescaled 32-bit up-counter with compare match, auto-reload and irq
module mmio_timer #(
   parameter logic [31:0] BASE_ADR = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Adress,
   input  logic        write_enable,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        hit,
   output logic        irq
);
   logic [2:0]  r_ctrl;
   logic [15:0] r_prescale;
   logic [31:0] r_count;
   logic [31:0] r_compare;
   logic        r_match;
   logic [15:0] r_pre;
   logic        w_hit;
   logic        w_we;
   logic [2:0]  w_off;
   logic        w_wr_ctrl;
   logic        w_wr_pre;
   logic        w_wr_count;
   logic        w_wr_compare;
   logic        w_wr_status;
   logic        w_tick;
   logic        w_eq;
   logic [31:0] w_rdata;
   logic        w_unused;
   assign w_hit        = Adress[31:5] == BASE_ADR[31:5];
   assign w_off        = Adress[4:2];
   assign w_we         = write_enable & w_hit;
   assign w_wr_ctrl    = w_we && w_off == 3'd0;
   assign w_wr_pre     = w_we && w_off == 3'd1;
   assign w_wr_count   = w_we && w_off == 3'd2;
   assign w_wr_compare = w_we && w_off == 3'd3;
   assign w_wr_status  = w_we && w_off == 3'd4;
   assign w_tick       = r_ctrl[0] && r_pre == r_prescale;
   assign w_eq         = r_count == r_compare;
   assign w_unused     = &{1'b0, Adress[1:0]};
   assign hit          = w_hit;
   assign irq          = r_match & r_ctrl[2];
   assign ReadData     = w_hit ? w_rdata : 32'd0;
   // read mux for the addressed word; reserved offsets read as zero
   always_comb begin
      w_rdata = (w_off == 3'd0) ? {29'd0, r_ctrl} :
                (w_off == 3'd1) ? {16'd0, r_prescale} :
                (w_off == 3'd2) ? r_count :
                (w_off == 3'd3) ? r_compare :
                (w_off == 3'd4) ? {31'd0, r_match} : 32'd0;
   end
   // control and configuration registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ctrl     <= 3'd0;
         r_prescale <= 16'd0;
         r_compare  <= 32'd0;
      end else begin
         if (w_wr_ctrl) r_ctrl <= WriteData[2:0];
         if (w_wr_pre) r_prescale <= WriteData[15:0];
         if (w_wr_compare) r_compare <= WriteData;
      end
   end
   // prescaler: restarts on any rate/control change so the new setting begins cleanly
   always_ff @(posedge clk) begin
      if (reset) r_pre <= 16'd0;
      else if (w_wr_ctrl || w_wr_pre) r_pre <= 16'd0;
      else if (r_ctrl[0]) r_pre <= w_tick ? 16'd0 : r_pre + 16'd1;
   end
   // main counter: a software write beats the tick increment
   always_ff @(posedge clk) begin
      if (reset) r_count <= 32'd0;
      else if (w_wr_count) r_count <= WriteData;
      else if (w_tick) r_count <= (w_eq && r_ctrl[1]) ? 32'd0 : r_count + 32'd1;
   end
   // sticky match flag: a new match outranks a simultaneous write-1-to-clear
   always_ff @(posedge clk) begin
      if (reset) r_match <= 1'b0;
      else if (w_tick && w_eq) r_match <= 1'b1;
      else if (w_wr_status && WriteData[0]) r_match <= 1'b0;
   end
endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: scoreboard-driven bench for the memory-mapped timer
module tb_mmio_timer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] Adress = 32'd0;
   logic        write_enable = 1'b0;
   logic [31:0] WriteData = 32'd0;
   logic [31:0] ReadData;
   logic        hit;
   logic        irq;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];

   mmio_timer dut (
      .clk(clk), .reset(reset), .Adress(Adress), .write_enable(write_enable),
      .WriteData(WriteData), .ReadData(ReadData), .hit(hit), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic apply_reset(input int n);
      @(negedge clk);
      reset = 1'b1;
      repeat (n) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      Adress = a;
      WriteData = d;
      write_enable = 1'b1;
      @(posedge clk);
      #1 write_enable = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      Adress = a;
      #1 v = ReadData;
   endtask

   task automatic cyc(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      logic [31:0] v, e;
      Adress = 32'h1008;
      apply_reset(2);
      exp_q.push_back(32'd0);
      rd(32'h1008, v);
      e = exp_q.pop_front();
      checks++;
      if (v !== e) begin errors++; $display("FAIL reset_rdata got %h exp %h", v, e); end
      checks++;
      if (hit !== 1'b1) begin errors++; $display("FAIL reset_hit got %b exp 1", hit); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
      exp_q.push_back(32'd0);
      rd(32'h1020, v);
      e = exp_q.pop_front();
      checks++;
      if (v !== e) begin errors++; $display("FAIL miss_rdata got %h exp %h", v, e); end
      checks++;
      if (hit !== 1'b0) begin errors++; $display("FAIL miss_hit got %b exp 0", hit); end
   endtask

   task automatic test_decode;
      logic [31:0] v, e;
      logic [31:0] a[10] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1010,
                             32'h100E, 32'h1004, 32'h1000, 32'h102C, 32'h1018};
      logic [31:0] x[10] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                             32'hABCD, 32'h0000_FFFF, 32'd0, 32'd0, 32'd0};
      foreach (a[i]) exp_q.push_back(x[i]);
      wr(32'h1020, 32'hDEAD);
      wr(32'h1024, 32'hDEAD);
      wr(32'h1028, 32'hDEAD);
      wr(32'h102C, 32'hDEAD);
      wr(32'h1030, 32'hDEAD);
      for (int i = 0; i < 5; i++) begin
         rd(a[i], v);
         e = exp_q.pop_front();
         checks++;
         if (v !== e) begin errors++; $display("FAIL decode_miss_write[%0d] got %h exp %h", i, v, e); end
      end
      wr(32'h100C, 32'hABCD);
      wr(32'h1004, 32'hFFFF_FFFF);
      wr(32'h1000, 32'hFFFF_FFF8);
      wr(32'h1014, 32'h1234);
      for (int i = 5; i < 10; i++) begin
         rd(a[i], v);
         e = exp_q.pop_front();
         checks++;
         if (v !== e) begin errors++; $display("FAIL decode_map[%0d] got %h exp %h", i, v, e); end
      end
      checks++;
      if (hit !== 1'b1) begin errors++; $display("FAIL reserved_hit got %b exp 1", hit); end
   endtask

   task automatic test_prescale;
      logic [31:0] v, e;
      int w[5] = '{0, 3, 1, 16, 10};
      logic [31:0] x[5] = '{32'd0, 32'd0, 32'd1, 32'd5, 32'd5};
      apply_reset(1);
      foreach (x[i]) exp_q.push_back(x[i]);
      wr(32'h1004, 32'd3);
      wr(32'h1000, 32'd1);
      for (int i = 0; i < 5; i++) begin
         if (i == 4) wr(32'h1000, 32'd0);
         cyc(w[i]);
         rd(32'h1008, v);
         e = exp_q.pop_front();
         checks++;
         if (v !== e) begin errors++; $display("FAIL prescale_count[%0d] got %h exp %h", i, v, e); end
      end
   endtask

   task automatic test_one_shot;
      logic [31:0] v, e;
      apply_reset(1);
      wr(32'h1004, 32'd0);
      wr(32'h100C, 32'd4);
      wr(32'h1000, 32'd5);
      exp_q.push_back(32'd4);
      exp_q.push_back(32'd5);
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd6);
      exp_q.push_back(32'd0);
      cyc(4);
      rd(32'h1008, v);
      e = exp_q.pop_front();
      checks++;
      if (v !== e) begin errors++; $display("FAIL oneshot_count4 got %h exp %h", v, e); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_early got %b exp 0", irq); end
      cyc(1);
      rd(32'h1008, v);
      e = exp_q.pop_front();
      checks++;
      if (v !== e) begin errors++; $display("FAIL oneshot_count5 got %h exp %h", v, e); end
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq_rise got %b exp 1", irq); end
      rd(32'h1010, v);
      e = exp_q.pop_front();
      checks++;
      if (v !== e) begin errors++; $display("FAIL oneshot_status got %h exp %h", v, e); end
      wr(32'h1010, 32'd1);
      rd(32'h1008, v);
      e = exp_q.pop_front();
      checks++;
      if (v !== e) begin errors++; $display("FAIL oneshot_count6 got %h exp %h", v, e); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_clear got %b exp 0", irq); end
      rd(32'h1010, v);
      e = exp_q.pop_front();
      checks++;
      if (v !== e) begin errors++; $display("FAIL oneshot_status_clear got %h exp %h", v, e); end
   endtask

   task automatic test_auto_reload;
      logic [31:0] v, e;
      logic [31:0] x[6] = '{32'd0, 32'd1, 32'd2, 32'd0, 32'd1, 32'd2};
      apply_reset(1);
      foreach (x[i]) exp_q.push_back(x[i]);
      wr(32'h1004, 32'd0);
      wr(32'h100C, 32'd2);
      wr(32'h1000, 32'd7);
      for (int i = 0; i < 6; i++) begin
         rd(32'h1008, v);
         e = exp_q.pop_front();
         checks++;
         if (v !== e) begin errors++; $display("FAIL reload_seq[%0d] got %h exp %h", i, v, e); end
         if (i < 5) cyc(1);
      end
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd0);
      wr(32'h1010, 32'd1);
      rd(32'h1010, v);
      e = exp_q.pop_front();
      checks++;
      if (v !== e) begin errors++; $display("FAIL reload_set_beats_clear got %h exp %h", v, e); end
      rd(32'h1008, v);
      e = exp_q.pop_front();
      checks++;
      if (v !== e) begin errors++; $display("FAIL reload_count_after got %h exp %h", v, e); end
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL reload_irq got %b exp 1", irq); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] v, e;
      apply_reset(1);
      exp_q.push_back(32'hFFFF_FFFF);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'h100);
      exp_q.push_back(32'd1);
      wr(32'h1004, 32'd0);
      wr(32'h100C, 32'd5);
      wr(32'h1000, 32'd1);
      wr(32'h1008, 32'hFFFF_FFFF);
      rd(32'h1008, v);
      e = exp_q.pop_front();
      checks++;
      if (v !== e) begin errors++; $display("FAIL wrap_written got %h exp %h", v, e); end
      cyc(1);
      rd(32'h1008, v);
      e = exp_q.pop_front();
      checks++;
      if (v !== e) begin errors++; $display("FAIL wrap_zero got %h exp %h", v, e); end
      rd(32'h1010, v);
      e = exp_q.pop_front();
      checks++;
      if (v !== e) begin errors++; $display("FAIL wrap_no_match got %h exp %h", v, e); end
      wr(32'h1008, 32'h100);
      rd(32'h1008, v);
      e = exp_q.pop_front();
      checks++;
      if (v !== e) begin errors++; $display("FAIL write_beats_tick got %h exp %h", v, e); end
      wr(32'h100C, 32'h103);
      cyc(4);
      rd(32'h1010, v);
      e = exp_q.pop_front();
      checks++;
      if (v !== e) begin errors++; $display("FAIL match_no_irq_en got %h exp %h", v, e); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_gated got %b exp 0", irq); end
   endtask

   task automatic test_reset_mid;
      logic [31:0] v, e;
      logic [31:0] a[5] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1010};
      apply_reset(1);
      wr(32'h1004, 32'd0);
      wr(32'h100C, 32'd3);
      wr(32'h1000, 32'd5);
      exp_q.push_back(32'd7);
      cyc(7);
      rd(32'h1008, v);
      e = exp_q.pop_front();
      checks++;
      if (v !== e) begin errors++; $display("FAIL midreset_pre_count got %h exp %h", v, e); end
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL midreset_pre_irq got %b exp 1", irq); end
      foreach (a[i]) exp_q.push_back(32'd0);
      @(negedge clk);
      reset = 1'b1;
      write_enable = 1'b1;
      Adress = 32'h1008;
      WriteData = 32'h55;
      @(posedge clk);
      #1;
      reset = 1'b0;
      write_enable = 1'b0;
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq got %b exp 0", irq); end
      for (int i = 0; i < 5; i++) begin
         rd(a[i], v);
         e = exp_q.pop_front();
         checks++;
         if (v !== e) begin errors++; $display("FAIL midreset_reg[%0d] got %h exp %h", i, v, e); end
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_prescale();
      test_one_shot();
      test_auto_reload();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
